// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared state codes, op codes, operand-select codes and strobe indices for the ALU sequencer
package alu_ctrl_pkg;
  localparam int W = 8;
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD_Q = 4'd1;
  localparam logic [3:0] S_LOAD_M = 4'd2;
  localparam logic [3:0] S_CLR_A  = 4'd3;
  localparam logic [3:0] S_EXAM   = 4'd4;
  localparam logic [3:0] S_MSHIFT = 4'd5;
  localparam logic [3:0] S_DSHIFT = 4'd6;
  localparam logic [3:0] S_DSUB   = 4'd7;
  localparam logic [3:0] S_DCHK   = 4'd8;
  localparam logic [3:0] S_DFIN   = 4'd9;
  localparam logic [3:0] S_DONE   = 4'd10;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_t;
  localparam logic [1:0] SEL_X    = 2'b00;
  localparam logic [1:0] SEL_Y    = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;
  localparam int C_LDQ = 0;
  localparam int C_LDM = 1;
  localparam int C_LDA = 2;
  localparam int C_SUB = 3;
  localparam int C_SHF = 4;
  localparam int C_CNT = 5;
  localparam int C_SIN = 6;
  localparam int C_OUT = 7;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational map from sequencer state and datapath status to strobes and operand select
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [1:0] op,
  input  logic       q0,
  input  logic       qm1,
  input  logic       first,
  input  logic       a7,
  input  logic       qbit,
  input  logic       err,
  output logic [7:0] c,
  output logic [1:0] opnd_sel
);
  logic [1:0] pair;
  always_comb begin
    pair = {q0, first ? 1'b0 : qm1};
    c = '0;
    opnd_sel = SEL_X;
    case (state)
      S_LOAD_Q: c[C_LDQ] = 1'b1;
      S_LOAD_M: begin
        opnd_sel = SEL_Y;
        c[C_LDM] = 1'b1;
      end
      S_CLR_A: begin
        opnd_sel = SEL_ZERO;
        c[C_LDA] = 1'b1;
      end
      S_EXAM: begin
        c[C_LDA] = ^pair;
        c[C_SUB] = pair == 2'b10;
      end
      S_MSHIFT: begin
        c[C_SHF] = 1'b1;
        c[C_CNT] = 1'b1;
        c[C_SIN] = a7;
      end
      S_DSHIFT: begin
        c[C_SHF] = 1'b1;
        c[C_CNT] = 1'b1;
        c[C_SIN] = qbit;
      end
      S_DSUB: begin
        c[C_LDA] = 1'b1;
        c[C_SUB] = 1'b1;
      end
      S_DCHK: c[C_LDA] = a7;
      // final shift brings in the last quotient bit; counter has already wrapped
      S_DFIN: begin
        c[C_SHF] = 1'b1;
        c[C_SIN] = qbit;
      end
      S_DONE: c[C_OUT] = op[1] & ~err;
      default: c = '0;
    endcase
  end
endmodule

// File: rtl/alu_control_unit.sv
// alu_control_unit: add/sub, Booth multiply and restoring divide sequencer for the 8-bit arithmetic unit
// DIV0_CHK_EN enables the divide-by-zero check that sets err and skips the divide loop.
module alu_control_unit
  import alu_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] in,
  input  logic         ack,
  input  logic         cnt_done,
  input  logic         q0,
  input  logic         qm1,
  input  logic         a7,
  output logic [7:0]   c,
  output logic [1:0]   opnd_sel,
  output logic         busy,
  output logic         done,
  output logic         err
);
  logic [3:0] state_q, state_d;
  logic qbit_q, qbit_d, first_q, first_d, last_q, last_d, err_q, err_d;
  logic div0;
`ifdef DIV0_CHK_EN
  assign div0 = op == OP_DIV && in == '0;
`else
  logic unused_in;
  assign unused_in = ^in;
  assign div0 = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    qbit_d = qbit_q;
    first_d = first_q;
    last_d = last_q;
    err_d = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD_Q;
        err_d = 1'b0;
      end
      S_LOAD_Q: state_d = S_LOAD_M;
      S_LOAD_M: begin
        state_d = op[1] ? S_CLR_A : S_DONE;
        err_d = err_q | div0;
      end
      S_CLR_A: begin
        first_d = 1'b1;
        qbit_d = 1'b0;
        state_d = err_q ? S_DONE : op[0] ? S_DSHIFT : S_EXAM;
      end
      S_EXAM: state_d = S_MSHIFT;
      S_MSHIFT: begin
        first_d = 1'b0;
        state_d = cnt_done ? S_DONE : S_EXAM;
      end
      S_DSHIFT: begin
        last_d = cnt_done;
        state_d = S_DSUB;
      end
      S_DSUB: state_d = S_DCHK;
      S_DCHK: begin
        qbit_d = ~a7;
        state_d = last_q ? S_DFIN : S_DSHIFT;
      end
      S_DFIN: state_d = S_DONE;
      S_DONE: state_d = ack ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      qbit_q <= 1'b0;
      first_q <= 1'b0;
      last_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      qbit_q <= qbit_d;
      first_q <= first_d;
      last_q <= last_d;
      err_q <= err_d;
    end
  end
  alu_ctrl_decode u_decode (
    .state(state_q),
    .op(op),
    .q0(q0),
    .qm1(qm1),
    .first(first_q),
    .a7(a7),
    .qbit(qbit_q),
    .err(err_q),
    .c(c),
    .opnd_sel(opnd_sel)
  );
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign err = err_q;
endmodule

// File: tb/tb_alu_control_unit.sv
// tb_alu_control_unit: drives the sequencer against a simple arithmetic-unit model and checks results arithmetically
module tb_alu_control_unit;
  logic clk = 1'b0;
  logic rst, start, ack, cnt_done, q0, qm1, a7, busy, done, err;
  logic [1:0] op, opnd_sel;
  logic [7:0] in, c, x, y, A, Q, M;
  logic dqm1;
  logic [2:0] cnt;
  logic [15:0] z;
  logic [7:0] cv [0:63];
  int checks = 0, errors = 0, lat, n_shf;

  always #5 clk = ~clk;

  alu_control_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in(in), .ack(ack),
    .cnt_done(cnt_done), .q0(q0), .qm1(qm1), .a7(a7),
    .c(c), .opnd_sel(opnd_sel), .busy(busy), .done(done), .err(err)
  );

  // Arithmetic unit model: bus mux, Q/M/A registers, Booth qm1, 3-bit iteration counter
  assign in = opnd_sel == 2'b01 ? y : opnd_sel == 2'b10 ? 8'h00 : x;
  assign q0 = Q[0];
  assign qm1 = dqm1;
  assign a7 = A[7];
  assign cnt_done = cnt == 3'd7;
  assign z = c[7] ? {A, Q} : {8'h00, op[0] ? Q - M : Q + M};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      A <= 8'h00; Q <= 8'h00; M <= 8'h00; dqm1 <= 1'b0; cnt <= 3'd0;
    end else begin
      if (c[0]) Q <= in;
      if (c[1]) M <= in;
      if (c[2]) A <= opnd_sel == 2'b10 ? 8'h00 : c[3] ? A - M : A + M;
      if (c[4] && op[0]) {A, Q} <= {A[6:0], Q, c[6]};
      if (c[4] && !op[0]) {A, Q, dqm1} <= {c[6], A, Q};
      if (c[5]) cnt <= cnt + 3'd1;
    end
  end

  task automatic run_op(input logic [7:0] xv, input logic [7:0] yv, input logic [1:0] ov);
    @(negedge clk);
    x = xv; y = yv; op = ov; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; n_shf = 0;
    while (!done && lat < 60) begin
      cv[lat] = c;
      if (c[4]) n_shf++;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL timeout waiting for done op=%0d got done=%b exp 1", ov, done); end
  endtask

  task automatic do_ack();
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1; ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ack = 1'b0; x = 8'h00; y = 8'h00; op = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (c !== 8'h00) begin errors++; $display("FAIL reset_c got %h exp 00", c); end
    checks++; if (opnd_sel !== 2'b00) begin errors++; $display("FAIL reset_sel got %b exp 00", opnd_sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_add();
    run_op(8'd23, 8'd19, 2'b00);
    checks++; if (lat != 3) begin errors++; $display("FAIL add_latency got %0d exp 3", lat); end
    checks++; if (cv[1] !== 8'h01) begin errors++; $display("FAIL add_ldq got %h exp 01", cv[1]); end
    checks++; if (cv[2] !== 8'h02) begin errors++; $display("FAIL add_ldm got %h exp 02", cv[2]); end
    checks++; if (z !== 16'd42) begin errors++; $display("FAIL add_z got %0d exp 42", z); end
    checks++; if (c[7] !== 1'b0) begin errors++; $display("FAIL add_c7 got %b exp 0", c[7]); end
    do_ack();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL add_ack_idle got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_mul();
    run_op(8'd13, 8'hFA, 2'b10);
    checks++; if (lat != 20) begin errors++; $display("FAIL mul_latency got %0d exp 20", lat); end
    checks++; if (n_shf != 8) begin errors++; $display("FAIL mul_shifts got %0d exp 8", n_shf); end
    checks++; if (c[7] !== 1'b1) begin errors++; $display("FAIL mul_c7 got %b exp 1", c[7]); end
    checks++; if (z !== 16'hFFB2) begin errors++; $display("FAIL mul_z got %h exp FFB2", z); end
    do_ack();
  endtask

  task automatic test_mul_stale();
    run_op(8'hFD, 8'd7, 2'b10);
    checks++; if (z !== 16'hFFEB) begin errors++; $display("FAIL mul_neg_z got %h exp FFEB", z); end
    do_ack();
    run_op(8'd3, 8'd5, 2'b10);
    checks++; if (z !== 16'd15) begin errors++; $display("FAIL mul_stale_z got %h exp 000F", z); end
    do_ack();
  endtask

  task automatic test_div();
    run_op(8'd100, 8'd7, 2'b11);
    checks++; if (lat != 29) begin errors++; $display("FAIL div_latency got %0d exp 29", lat); end
    checks++; if (z[7:0] !== 8'h0E) begin errors++; $display("FAIL div_quot got %h exp 0E", z[7:0]); end
    checks++; if (z[15:8] !== 8'h04) begin errors++; $display("FAIL div_rem got %h exp 04", z[15:8]); end
    checks++; if (c[7] !== 1'b1) begin errors++; $display("FAIL div_c7 got %b exp 1", c[7]); end
    do_ack();
  endtask

  task automatic test_ignored();
    run_op(8'd1, 8'd2, 2'b01);
    @(negedge clk); start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL start_in_done got done=%b exp 1", done); end
    start = 1'b0;
    do_ack();
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1; ack = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ack_in_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_rst_mid();
    int k = 0, g = 0;
    @(negedge clk);
    x = 8'd9; y = 8'd11; op = 2'b10; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    while (k < 3 && g < 100) begin
      if (c[4]) k++;
      @(posedge clk); #1;
      g++;
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (c !== 8'h00) begin errors++; $display("FAIL rst_mid_c got %h exp 00", c); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    @(negedge clk); rst = 1'b0;
    run_op(8'd2, 8'd3, 2'b10);
    checks++; if (z !== 16'd6) begin errors++; $display("FAIL rst_then_mul got %h exp 0006", z); end
    do_ack();
  endtask

  task automatic test_div0();
    run_op(8'd50, 8'd0, 2'b11);
`ifdef DIV0_CHK_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL div0_err got %b exp 1", err); end
    checks++; if (lat != 4) begin errors++; $display("FAIL div0_latency got %0d exp 4", lat); end
    checks++; if (n_shf != 0) begin errors++; $display("FAIL div0_shifts got %0d exp 0", n_shf); end
    checks++; if (c[7] !== 1'b0) begin errors++; $display("FAIL div0_c7 got %b exp 0", c[7]); end
`else
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL div0_err got %b exp 0", err); end
    checks++; if (lat != 29) begin errors++; $display("FAIL div0_latency got %0d exp 29", lat); end
`endif
    do_ack();
    run_op(8'd5, 8'd6, 2'b00);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
    checks++; if (z !== 16'd11) begin errors++; $display("FAIL after_div0_z got %0d exp 11", z); end
    do_ack();
  endtask

  task automatic test_random();
    int exp_lat [4] = '{3, 3, 20, 29};
    for (int i = 0; i < 24; i++) begin
      logic [1:0] o;
      logic [7:0] xv, yv, qq, rr;
      logic [15:0] ez;
      int xs, ys;
      o = 2'($urandom_range(0, 3));
      xv = 8'($urandom);
      yv = o == 2'b11 ? 8'($urandom_range(1, 127)) : 8'($urandom);
      xs = $signed(xv);
      ys = $signed(yv);
      qq = 8'(int'(xv) / int'(yv == 0 ? 8'd1 : yv));
      rr = 8'(int'(xv) % int'(yv == 0 ? 8'd1 : yv));
      ez = o == 2'b00 ? {8'h00, 8'(xv + yv)} :
           o == 2'b01 ? {8'h00, 8'(xv - yv)} :
           o == 2'b10 ? 16'(xs * ys) : {8'(rr << 1), qq};
      run_op(xv, yv, o);
      checks++; if (lat != exp_lat[o]) begin errors++; $display("FAIL rand_latency op=%0d got %0d exp %0d", o, lat, exp_lat[o]); end
      checks++; if (z !== ez) begin errors++; $display("FAIL rand_z op=%0d x=%0d y=%0d got %h exp %h", o, xv, yv, z, ez); end
      do_ack();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_mul_stale();
    test_div();
    test_ignored();
    test_rst_mid();
    test_div0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
